// File: rtl/aha_clk_div_sel_pkg.sv
// Shared types, ratio codes and sizing helpers for the clock-divider
// enable selector.
package aha_clk_div_sel_pkg;

    localparam int DIV_CODE_W = 3;

    localparam logic [DIV_CODE_W-1:0] DIV_BY_1  = 3'd0;
    localparam logic [DIV_CODE_W-1:0] DIV_BY_2  = 3'd1;
    localparam logic [DIV_CODE_W-1:0] DIV_BY_4  = 3'd2;
    localparam logic [DIV_CODE_W-1:0] DIV_BY_8  = 3'd3;
    localparam logic [DIV_CODE_W-1:0] DIV_BY_16 = 3'd4;
    localparam logic [DIV_CODE_W-1:0] DIV_BY_32 = 3'd5;
    localparam logic [DIV_CODE_W-1:0] DIV_MAX   = DIV_BY_32;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ALIGN,
        SWITCH
    } sel_state_e;

    // The slower of two ratios decides when both enables line up.
    function automatic logic [DIV_CODE_W-1:0] slower_code(
        input logic [DIV_CODE_W-1:0] a,
        input logic [DIV_CODE_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

    // Counter width able to hold the larger of the two terminal counts.
    function automatic int cnt_width(input int drain_cycles, input int timeout);
        int longest;
        int w;
        longest = (drain_cycles > timeout) ? drain_cycles : timeout;
        w = $clog2(longest);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/aha_clk_div_sel_cnt.sv
// Clear/enable up-counter with a terminal-count flag. One instance serves
// both the drain delay and the alignment timeout of the selector.
module aha_clk_div_sel_cnt #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic             at_term
);

    logic [WIDTH-1:0] count;

    // Count up while enabled, holding at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    // Greater-or-equal keeps the flag asserted even if the count overshoots.
    assign at_term = (count >= term);

endmodule

// File: rtl/aha_clk_div_selector.sv
// Consumer end of the clock-divider enable bus. Picks one of the
// divide-by-2^k enables and presents it as a single gated clock-enable.
// Ratio changes are requested over valid/ready and applied glitch-free:
// the output is masked, the switch waits for a cycle where both the old
// and new enables coincide, then the new ratio takes over.
module aha_clk_div_selector
    import aha_clk_div_sel_pkg::*;
#(
    parameter int RESET_DIV    = 0,
    parameter int DRAIN_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] en_by,
    input  logic       req_valid,
    input  logic [2:0] req_div,
    output logic       req_ready,
    output logic       gated_en,
    output logic [2:0] cur_div,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int CNT_W = cnt_width(DRAIN_CYCLES, TIMEOUT);
    localparam logic [CNT_W-1:0] DRAIN_TERM = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] ALIGN_TERM = CNT_W'(TIMEOUT - 1);
    localparam logic [DIV_CODE_W-1:0] RESET_CODE = DIV_CODE_W'(RESET_DIV);

    sel_state_e            state_q;
    sel_state_e            state_d;
    logic [DIV_CODE_W-1:0] cur_q;
    logic [DIV_CODE_W-1:0] cur_d;
    logic [DIV_CODE_W-1:0] tgt_q;
    logic [DIV_CODE_W-1:0] tgt_d;
    logic                  mask_q;
    logic                  mask_d;
    logic                  done_q;
    logic                  done_d;
    logic                  err_q;
    logic                  err_d;

    logic                  cnt_clear;
    logic                  cnt_enable;
    logic [CNT_W-1:0]      cnt_term;
    logic                  cnt_at_term;
    logic [DIV_CODE_W-1:0] slow_code;

    aha_clk_div_sel_cnt #(
        .WIDTH (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .term    (cnt_term),
        .at_term (cnt_at_term)
    );

    assign slow_code = slower_code(cur_q, tgt_q);

    // State and control registers; reset restores the power-on ratio and
    // drops any switch in flight without a completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cur_q   <= RESET_CODE;
            tgt_q   <= RESET_CODE;
            mask_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tgt_q   <= tgt_d;
            mask_q  <= mask_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic: accept or reject requests, drain, wait for the
    // common enable edge (or give up), then commit the new ratio.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tgt_d      = tgt_q;
        mask_d     = mask_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        cnt_term   = DRAIN_TERM;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    tgt_d = req_div;
                    if (req_div > DIV_MAX) begin
                        err_d = 1'b1;
                    end else if (req_div == cur_q) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = DRAIN;
                        mask_d    = 1'b1;
                        cnt_clear = 1'b1;
                    end
                end
            end

            DRAIN: begin
                cnt_term = DRAIN_TERM;
                if (cnt_at_term) begin
                    state_d   = ALIGN;
                    cnt_clear = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            ALIGN: begin
                cnt_term = ALIGN_TERM;
                if (en_by[slow_code]) begin
                    state_d = SWITCH;
                end else if (cnt_at_term) begin
                    state_d = IDLE;
                    mask_d  = 1'b0;
                    err_d   = 1'b1;
                end else begin
                    cnt_enable = 1'b1;
                end
            end

            SWITCH: begin
                cur_d   = tgt_q;
                mask_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                mask_d  = 1'b0;
            end
        endcase
    end

    assign gated_en  = en_by[cur_q] & ~mask_q;
    assign cur_div   = cur_q;
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_aha_clk_div_selector.sv
// Self-checking bench for the clock-divider enable selector. The divider
// enables come from a free-running phase counter; expected outputs are
// predicted per request from cycle arithmetic over that phase.
module tb_aha_clk_div_selector;

    localparam int RESET_DIV    = 0;
    localparam int DRAIN_CYCLES = 2;
    localparam int TIMEOUT      = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] en_by;
    logic       req_valid = 1'b0;
    logic [2:0] req_div = 3'd0;
    logic       req_ready;
    logic       gated_en;
    logic [2:0] cur_div;
    logic       busy;
    logic       done;
    logic       err;

    int cyc = 0;
    int phase0 = 0;
    bit kill5 = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [2:0] m_cur = 3'(RESET_DIV);
    logic [2:0] m_new = 3'd0;
    int win_lo = -1;
    int win_hi = -2;
    int done_at = -1;
    int err_at = -1;
    int cur_at = -1;

    aha_clk_div_selector #(
        .RESET_DIV    (RESET_DIV),
        .DRAIN_CYCLES (DRAIN_CYCLES),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en_by     (en_by),
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .gated_en  (gated_en),
        .cur_div   (cur_div),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Divider enable pattern for cycle n: divide-by-2^k fires when the
    // low k bits of the divider phase are all ones.
    function automatic logic [5:0] en_vec(input int n);
        logic [5:0] v;
        int p;
        p = (phase0 + n) % 32;
        for (int k = 0; k < 6; k++) begin
            v[k] = ((p % (1 << k)) == ((1 << k) - 1));
        end
        if (kill5) v[5] = 1'b0;
        return v;
    endfunction

    // Divider model driving the enable bus just after each clock edge.
    initial begin
        phase0 = $urandom_range(0, 31);
        en_by = en_vec(0);
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            en_by = en_vec(cyc);
        end
    end

    task automatic compare(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkOutput();
        logic [5:0] ev;
        logic       exp_mask;
        if (cyc == cur_at) m_cur = m_new;
        exp_mask = (cyc >= win_lo) && (cyc <= win_hi);
        ev = en_vec(cyc);
        compare("gated_en", 3'(gated_en), exp_mask ? 3'd0 : 3'(ev[m_cur]));
        compare("cur_div", cur_div, m_cur);
        compare("busy", 3'(busy), 3'(exp_mask));
        compare("req_ready", 3'(req_ready), 3'(!exp_mask));
        compare("done", 3'(done), 3'(cyc == done_at));
        compare("err", 3'(err), 3'(cyc == err_at));
    endtask

    task automatic step();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic modelReset();
        m_cur   = 3'(RESET_DIV);
        win_lo  = -1;
        win_hi  = -2;
        done_at = -1;
        err_at  = -1;
        cur_at  = -1;
    endtask

    // Issue one request from IDLE, predict its outcome, then run until the
    // predicted DONE/ERR cycle while poking the channel during the busy window.
    task automatic applyStimulus(input logic [2:0] code);
        int a;
        int last;
        int c;
        bit found;
        logic [2:0] slow;
        logic [5:0] ev;
        a = cyc;
        req_valid = 1'b1;
        req_div = code;
        if (code > 3'd5) begin
            err_at = a + 1;
            last = a + 1;
        end else if (code == m_cur) begin
            done_at = a + 1;
            last = a + 1;
        end else begin
            slow = (m_cur > code) ? m_cur : code;
            win_lo = a + 1;
            found = 1'b0;
            c = a + DRAIN_CYCLES + 1;
            while (!found && (c <= a + DRAIN_CYCLES + TIMEOUT)) begin
                ev = en_vec(c);
                if (ev[slow]) found = 1'b1;
                else c++;
            end
            if (found) begin
                win_hi  = c + 1;
                done_at = c + 2;
                cur_at  = c + 2;
                m_new   = code;
                last    = c + 2;
            end else begin
                win_hi = a + DRAIN_CYCLES + TIMEOUT;
                err_at = a + DRAIN_CYCLES + TIMEOUT + 1;
                last   = err_at;
            end
        end
        step();
        req_valid = 1'b0;
        while (cyc < last) begin
            step();
            req_valid = (cyc >= win_lo && cyc <= win_hi) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_div = 3'($urandom_range(0, 7));
        end
        req_valid = 1'b0;
    endtask

    initial begin
        $display("[TB] start, divider phase %0d", phase0);
        modelReset();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        applyStimulus(3'd3);
        repeat (20) step();

        applyStimulus(3'd5);
        applyStimulus(3'd1);
        repeat (10) step();

        applyStimulus(3'd6);
        applyStimulus(3'd1);
        applyStimulus(3'd7);

        applyStimulus(3'd2);
        kill5 = 1'b1;
        applyStimulus(3'd5);
        kill5 = 1'b0;
        repeat (10) step();

        kill5 = 1'b1;
        win_lo = cyc + 1;
        win_hi = cyc + 100000;
        req_valid = 1'b1;
        req_div = 3'd5;
        step();
        req_valid = 1'b0;
        repeat (DRAIN_CYCLES + 3) step();
        rst_n = 1'b0;
        #1;
        kill5 = 1'b0;
        modelReset();
        checkOutput();
        step();
        rst_n = 1'b1;
        repeat (5) step();

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 5)) step();
            applyStimulus(3'($urandom_range(0, 7)));
        end
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
